// File: rtl/subsurf_pkg.sv
// Shared RAM geometry, request record and requester indices.
// No logic; constants and types only.
// No flow control here.
package subsurf_pkg;

  localparam int RAM_AW  = 9;
  localparam int RAM_DW  = 32;
  localparam int RAM_WEW = 4;

  // One requester's access: byte enables (0 = read), word address, write data.
  typedef struct packed {
    logic [RAM_WEW-1:0] we;
    logic [RAM_AW-1:0]  a;
    logic [RAM_DW-1:0]  di;
  } ram_req_t;

  localparam int REQ_NEIGHBOR = 0;
  localparam int REQ_POINTS   = 1;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping.
// Latency: purely combinational.
// No backpressure; an empty request vector gives an all-zero grant.
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] idx;
  logic          found;

  // Scan N positions starting at ptr and grant the first requester seen.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between N_REQ requesters, round-robin with bounded locking.
// Latency: grant and RAM access same cycle; read data and rvalid one cycle after grant.
// Backpressure: requesters hold req until gnt; a locked owner yields after MAX_LOCK grants.
module ram_port_arbiter
  import subsurf_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int AW       = RAM_AW,
  parameter int DW       = RAM_DW,
  parameter int MAX_LOCK = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          lock,
  input  logic [N_REQ*(DW/8)-1:0]   req_we,
  input  logic [N_REQ*AW-1:0]       req_a,
  input  logic [N_REQ*DW-1:0]       req_di,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          rvalid,
  output logic [DW-1:0]             rdata,
  output logic                      RAM_EN,
  output logic [DW/8-1:0]           RAM_WE,
  output logic [AW-1:0]             RAM_A,
  output logic [DW-1:0]             RAM_Di,
  input  logic [DW-1:0]             RAM_Do
);

  localparam int WEW = DW / 8;
  localparam int PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW  = $clog2(MAX_LOCK + 1);

  if (N_REQ < 2 || N_REQ > 4) begin : g_bad_n_req
    $error("ram_port_arbiter: N_REQ must be in 2..4");
  end

  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic             owner_vld_q, owner_vld_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [CW-1:0]    lock_cnt_q, lock_cnt_d;
  logic             rd_vld_q, rd_vld_d;
  logic [PW-1:0]    rd_tag_q, rd_tag_d;

  logic [N_REQ-1:0] owner_mask;
  logic             owner_req;
  logic             skip;
  logic [N_REQ-1:0] pick_req;
  logic [N_REQ-1:0] rr_gnt;
  logic             any_gnt;
  logic [PW-1:0]    gidx;

  // Decide whether the locked owner keeps the port or must yield this cycle.
  always_comb begin
    owner_mask          = '0;
    owner_mask[owner_q] = owner_vld_q;
    owner_req           = owner_vld_q && req[owner_q];
    skip                = owner_req && (lock_cnt_q == CW'(MAX_LOCK)) && |(req & ~owner_mask);
    pick_req            = skip ? (req & ~owner_mask) : req;
  end

  rr_pick #(.N(N_REQ)) u_rr_pick (
    .req (pick_req),
    .ptr (rr_ptr_q),
    .gnt (rr_gnt)
  );

  // Final grant, suppressed while reset is held, and the RAM pin mux.
  always_comb begin
    gnt     = '0;
    gidx    = '0;
    RAM_WE  = '0;
    RAM_A   = '0;
    RAM_Di  = '0;
    if (rst_n) gnt = (owner_req && !skip) ? owner_mask : rr_gnt;
    any_gnt = |gnt;
    RAM_EN  = any_gnt;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        gidx   = PW'(i);
        RAM_WE = req_we[i*WEW +: WEW];
        RAM_A  = req_a[i*AW +: AW];
        RAM_Di = req_di[i*DW +: DW];
      end
    end
  end

  // Next-state for pointer, lock ownership and the read return tag.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    owner_vld_d = owner_vld_q;
    owner_d     = owner_q;
    lock_cnt_d  = lock_cnt_q;
    rd_vld_d    = any_gnt && (RAM_WE == '0);
    rd_tag_d    = any_gnt ? gidx : rd_tag_q;

    if (any_gnt) rr_ptr_d = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + PW'(1);

    if (skip) begin
      owner_vld_d = 1'b0;
      lock_cnt_d  = '0;
    end else if (any_gnt && lock[gidx]) begin
      owner_vld_d = 1'b1;
      owner_d     = gidx;
      if (owner_vld_q && owner_q == gidx)
        lock_cnt_d = (lock_cnt_q == CW'(MAX_LOCK)) ? lock_cnt_q : lock_cnt_q + CW'(1);
      else
        lock_cnt_d = CW'(1);
    end else if (owner_vld_q && ((any_gnt && owner_q == gidx) || !req[owner_q])) begin
      owner_vld_d = 1'b0;
      lock_cnt_d  = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      owner_vld_q <= 1'b0;
      owner_q     <= '0;
      lock_cnt_q  <= '0;
      rd_vld_q    <= 1'b0;
      rd_tag_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      owner_vld_q <= owner_vld_d;
      owner_q     <= owner_d;
      lock_cnt_q  <= lock_cnt_d;
      rd_vld_q    <= rd_vld_d;
      rd_tag_q    <= rd_tag_d;
    end
  end

  // Read return: macro output is already registered, so only the tag is steered.
  always_comb begin
    rvalid = '0;
    if (rst_n && rd_vld_q) rvalid[rd_tag_q] = 1'b1;
    rdata = RAM_Do;
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_req_stable
    a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (req[i] && !gnt[i]) ##1 req[i] |->
        $stable(req_we[i*WEW +: WEW]) && $stable(req_a[i*AW +: AW]) && $stable(req_di[i*DW +: DW]));
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a behavioural DFFRAM512x32.
// Expected grants and read returns are queued by stimulus, checked by a monitor.
// Every wait is bounded by a cycle budget.
module tb_ram_port_arbiter;
  import subsurf_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, lock, gnt, rvalid;
  logic [7:0]  req_we;
  logic [17:0] req_a;
  logic [63:0] req_di;
  logic [31:0] rdata, ram_di, ram_do;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [8:0]  ram_a;
  logic [31:0] mem [512];

  always #5 clk = ~clk;

  ram_port_arbiter #(.N_REQ(2), .AW(9), .DW(32), .MAX_LOCK(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .req_we(req_we),
    .req_a(req_a), .req_di(req_di), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .RAM_EN(ram_en), .RAM_WE(ram_we), .RAM_A(ram_a), .RAM_Di(ram_di), .RAM_Do(ram_do)
  );

  // Behavioural DFFRAM512x32: byte writes, registered read output.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we == 4'b0000) ram_do <= mem[ram_a];
      else for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_a][b*8 +: 8] <= ram_di[b*8 +: 8];
    end
  end

  typedef struct { ram_req_t r; logic lk; logic [31:0] exp; } op_t;
  typedef struct { int tag; logic [31:0] dat; } rd_exp_t;

  op_t     ops0[$];
  op_t     ops1[$];
  int      exp_gnt[$];
  rd_exp_t exp_rd[$];
  int      checks   = 0;
  int      failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  function automatic op_t mk(input logic [3:0] we, input logic [8:0] a, input logic [31:0] di,
                             input logic lk, input logic [31:0] exp);
    op_t o;
    o.r.we = we; o.r.a = a; o.r.di = di; o.lk = lk; o.exp = exp;
    return o;
  endfunction

  // Monitor: every grant and every read return must match the head of its queue.
  initial begin
    int      ge;
    rd_exp_t re;
    forever begin
      @(negedge clk);
      if (gnt !== 2'b00) begin
        if (exp_gnt.size() == 0) check("gnt_unexpected", gnt, 0);
        else begin
          ge = exp_gnt.pop_front();
          check("gnt_order", gnt, 64'(2'b01 << ge));
        end
      end
      if (rvalid !== 2'b00) begin
        if (exp_rd.size() == 0) check("rvalid_unexpected", rvalid, 0);
        else begin
          re = exp_rd.pop_front();
          check("rvalid_tag", rvalid, 64'(2'b01 << re.tag));
          check("rdata", rdata, re.dat);
        end
      end
    end
  end

  // Present queued ops on both requesters; advance a requester only after its grant.
  task automatic run_ops(input int budget);
    op_t        c0, c1;
    logic       a0, a1;
    logic [1:0] g;
    int         cyc;
    cyc = 0;
    c0 = mk(4'h0, 9'h0, 32'h0, 1'b0, 32'h0);
    c1 = c0;
    a0 = ops0.size() > 0;
    if (a0) c0 = ops0.pop_front();
    a1 = ops1.size() > 0;
    if (a1) c1 = ops1.pop_front();
    while ((a0 || a1) && cyc < budget) begin
      req    = {a1, a0};
      lock   = {a1 & c1.lk, a0 & c0.lk};
      req_we = {c1.r.we, c0.r.we};
      req_a  = {c1.r.a, c0.r.a};
      req_di = {c1.r.di, c0.r.di};
      @(negedge clk);
      g = gnt;
      if (a0 && g[0] && c0.r.we == 4'h0) exp_rd.push_back('{REQ_NEIGHBOR, c0.exp});
      if (a1 && g[1] && c1.r.we == 4'h0) exp_rd.push_back('{REQ_POINTS, c1.exp});
      @(posedge clk); #1;
      cyc++;
      if (a0 && g[0]) begin a0 = ops0.size() > 0; if (a0) c0 = ops0.pop_front(); end
      if (a1 && g[1]) begin a1 = ops1.size() > 0; if (a1) c1 = ops1.pop_front(); end
    end
    req  = 2'b00;
    lock = 2'b00;
    check("ops_completed", {a1, a0}, 0);
    ops0.delete();
    ops1.delete();
  endtask

  initial begin
    rst_n = 1'b0; req = '0; lock = '0; req_we = '0; req_a = '0; req_di = '0;
    repeat (2) @(posedge clk);
    #1 req = 2'b11;
    @(negedge clk);
    check("reset_gnt", gnt, 0);
    check("reset_ram_en", ram_en, 0);
    check("reset_rvalid", rvalid, 0);
    @(posedge clk); #1;
    req = 2'b00; rst_n = 1'b1;
    @(posedge clk); #1;

    // Write then read back; then requester 1 seeds 0x020.
    ops0.push_back(mk(4'hF, 9'h010, 32'hDEADBEEF, 1'b0, 32'h0));
    ops0.push_back(mk(4'h0, 9'h010, 32'h0, 1'b0, 32'hDEADBEEF));
    exp_gnt.push_back(0); exp_gnt.push_back(0);
    run_ops(20);
    ops1.push_back(mk(4'hF, 9'h020, 32'h12345678, 1'b0, 32'h0));
    exp_gnt.push_back(1);
    run_ops(20);

    // Fairness: both requesters hold reads, grants alternate starting at 0.
    for (int i = 0; i < 8; i++) begin
      ops0.push_back(mk(4'h0, 9'h010, 32'h0, 1'b0, 32'hDEADBEEF));
      ops1.push_back(mk(4'h0, 9'h020, 32'h0, 1'b0, 32'h12345678));
      exp_gnt.push_back(0); exp_gnt.push_back(1);
    end
    run_ops(40);

    // Locked read-modify-write on 0x020 keeps requester 1 out until the lock drops.
    ops0.push_back(mk(4'h0, 9'h020, 32'h0, 1'b1, 32'h12345678));
    ops0.push_back(mk(4'b0011, 9'h020, 32'h0000ABCD, 1'b0, 32'h0));
    ops1.push_back(mk(4'h0, 9'h020, 32'h0, 1'b0, 32'h1234ABCD));
    exp_gnt.push_back(0); exp_gnt.push_back(0); exp_gnt.push_back(1);
    run_ops(20);

    // Starvation bound: 16 locked grants to 0, then 1 is forced in, then 0 resumes.
    for (int i = 0; i < 17; i++) ops0.push_back(mk(4'h0, 9'h010, 32'h0, 1'b1, 32'hDEADBEEF));
    ops1.push_back(mk(4'h0, 9'h020, 32'h0, 1'b0, 32'h1234ABCD));
    for (int i = 0; i < 16; i++) exp_gnt.push_back(0);
    exp_gnt.push_back(1); exp_gnt.push_back(0);
    run_ops(60);

    // Reset on the cycle after a read grant drops the return and the pointer.
    exp_gnt.push_back(0);
    req = 2'b01; req_we[3:0] = 4'h0; req_a[8:0] = 9'h010;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0; req = 2'b11;
    @(negedge clk);
    check("midreset_rvalid", rvalid, 0);
    check("midreset_gnt", gnt, 0);
    check("midreset_ram_en", ram_en, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; req = 2'b00;
    @(posedge clk); #1;
    ops0.push_back(mk(4'h0, 9'h010, 32'h0, 1'b0, 32'hDEADBEEF));
    ops1.push_back(mk(4'h0, 9'h020, 32'h0, 1'b0, 32'h1234ABCD));
    exp_gnt.push_back(0); exp_gnt.push_back(1);
    run_ops(20);

    // Idle: no requests means the macro stays disabled.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_ram_en", ram_en, 0);
      @(posedge clk); #1;
    end

    // Single-byte write merges into the existing word.
    ops0.push_back(mk(4'hF, 9'h030, 32'h11223344, 1'b0, 32'h0));
    ops0.push_back(mk(4'b1000, 9'h030, 32'hAA000000, 1'b0, 32'h0));
    ops0.push_back(mk(4'h0, 9'h030, 32'h0, 1'b0, 32'hAA223344));
    exp_gnt.push_back(0); exp_gnt.push_back(0); exp_gnt.push_back(0);
    run_ops(20);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("gnt_queue_drained", exp_gnt.size(), 0);
    check("rd_queue_drained", exp_rd.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
